// File: rtl/coin_entry_conditioner.sv
// Coin-entry front end for the vending controller.
// Synchronizes and debounces a bouncy active-low pushbutton together with the
// coin-type switches. Each accepted press produces exactly one registered
// coin pulse, or a reject pulse if no coin type is selected. A saturating
// count of accepted coins is also kept.
module coin_entry_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic [1:0] coin_sel,
  output logic [1:0] coin,
  output logic       coin_valid,
  output logic       reject,
  output logic       busy,
  output logic [7:0] coin_count
);

  localparam int unsigned CNT_W = 16;

  // Terminal count: the D-th consecutive stable cycle has been observed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    EMIT         = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       coin_lat;

  // Two-flop synchronizers. Stage _p0 may go metastable and _p1 is the
  // clean sample. key_p1 is the synchronized key (key_s) and sel_p1 is
  // the synchronized coin select (sel_s).
  logic       key_p0;
  logic       key_p1;
  logic [1:0] sel_p0;
  logic [1:0] sel_p1;

  // Saturating increment for the coin counter. It holds at all-ones
  // instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end
    return val + 8'd1;
  endfunction

  // Whether the latched coin code names a real coin type.
  function automatic logic is_coin(input logic [1:0] sel);
    return (sel != 2'b00);
  endfunction

  // Input synchronizers. The reset values match the released button with
  // no coin selected, so a key held through reset is seen as a fresh edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      sel_p0 <= 2'b00;
      sel_p1 <= 2'b00;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
      sel_p0 <= coin_sel;
      sel_p1 <= sel_p0;
    end
  end

  // ---- stage boundary: synchronized inputs -> debounce FSM ----

  // Debounce FSM with registered outputs. The coin and reject pulses are
  // loaded on the edge that enters EMIT, so they are high for exactly the
  // one cycle that state lasts. busy tracks the next state, so it is
  // registered in step with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      coin_lat   <= 2'b00;
      coin       <= 2'b00;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
      busy       <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      // Pulse outputs default low and are raised only when entering EMIT.
      coin       <= 2'b00;
      coin_valid <= 1'b0;
      reject     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!key_p1) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        PRESS_WAIT: begin
          if (key_p1) begin
            // Bounce: the key went high before it was stable long enough.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= EMIT;
            coin_lat <= sel_p1;
            if (is_coin(sel_p1)) begin
              coin       <= sel_p1;
              coin_valid <= 1'b1;
              coin_count <= sat_inc(coin_count);
            end else begin
              reject <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        EMIT: begin
          state <= HELD;
        end

        HELD: begin
          // The coin is already latched, so a long hold or a change of
          // coin_sel here has no further effect.
          if (key_p1) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (!key_p1) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Coin and reject are mutually exclusive, and a pulse always comes from
  // a busy conditioner.
  a_pulse_excl : assert property (@(posedge clock) disable iff (reset)
    !(coin_valid && reject));
  a_pulse_busy : assert property (@(posedge clock) disable iff (reset)
    (coin_valid || reject) |-> busy);
  a_coin_zero  : assert property (@(posedge clock) disable iff (reset)
    !coin_valid |-> (coin == 2'b00));
  a_coin_lat   : assert property (@(posedge clock) disable iff (reset)
    coin_valid |-> (coin == coin_lat));

endmodule

// File: tb/tb_coin_entry_conditioner.sv
// Scoreboard bench for coin_entry_conditioner with a short debounce (D=4).
module tb_coin_entry_conditioner;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_n;
  logic [1:0] coin_sel;
  logic [1:0] coin;
  logic       coin_valid;
  logic       reject;
  logic       busy;
  logic [7:0] coin_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_count = 0;

  typedef struct {
    logic [1:0] coin;
    logic       valid;
    logic       rej;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  coin_entry_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .coin_sel   (coin_sel),
    .coin       (coin),
    .coin_valid (coin_valid),
    .reject     (reject),
    .busy       (busy),
    .coin_count (coin_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge in the same step where key_n is driven low.
  // The key is first sampled at the next edge, and the pulse follows D+2
  // edges after that.
  task automatic push_exp(input logic [1:0] sel);
    exp_t e;
    e.cyc = cyc + D + 3;
    if (sel != 2'b00) begin
      if (exp_count < 255) exp_count++;
      e.coin = sel; e.valid = 1'b1; e.rej = 1'b0;
    end else begin
      e.coin = 2'b00; e.valid = 1'b0; e.rej = 1'b1;
    end
    e.cnt = exp_count;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic press(input logic [1:0] sel, input int hold);
    @(negedge clock);
    coin_sel = sel;
    key_n    = 1'b0;
    push_exp(sel);
    repeat (hold) @(negedge clock);
    key_n = 1'b1;
    wait_idle();
  endtask

  // Output monitor: pops the scoreboard for every pulse.
  always @(negedge clock) begin
    if (coin_valid || reject) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("coin",       coin,       mon_e.coin);
        chk("coin_valid", coin_valid, mon_e.valid);
        chk("reject",     reject,     mon_e.rej);
        chk("coin_count", coin_count, mon_e.cnt);
        chk("latency",    cyc,        mon_e.cyc);
      end
    end else if (coin != 2'b00) begin
      chk("coin_idle", coin, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    key_n    = 1'b1;
    coin_sel = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_coin",       coin,       0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_reject",     reject,     0);
    chk("rst_busy",       busy,       0);
    chk("rst_count",      coin_count, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Basic press with coin 10, held 20 cycles; coin_sel changes after the latch.
    coin_sel = 2'b10;
    key_n    = 1'b0;
    push_exp(2'b10);
    @(negedge clock);                      // after edge 0
    @(negedge clock);                      // after edge 1
    chk("busy_edge1", busy, 0);
    @(negedge clock);                      // after edge 2
    chk("busy_edge2", busy, 1);
    repeat (6) @(negedge clock);           // past the pulse
    coin_sel = 2'b01;
    repeat (11) @(negedge clock);
    key_n = 1'b1;
    wait_idle();
    chk("count_after_first", coin_count, 1);

    // Short glitch: low for 3 cycles, then high.
    @(negedge clock);
    coin_sel = 2'b11;
    key_n    = 1'b0;
    repeat (3) @(negedge clock);
    key_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("glitch_busy",  busy,       0);
    chk("glitch_count", coin_count, exp_count);

    // Valid press followed by a bouncy release: high 2, low 1, then high.
    coin_sel = 2'b01;
    key_n    = 1'b0;
    push_exp(2'b01);
    repeat (10) @(negedge clock);
    key_n = 1'b1;
    repeat (2) @(negedge clock);
    key_n = 1'b0;
    @(negedge clock);
    key_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("bounce_busy_before", busy, 1);
    @(negedge clock);
    chk("bounce_busy_idle", busy, 0);
    repeat (4) @(negedge clock);

    // No coin selected gives a reject pulse.
    press(2'b00, 10);
    chk("reject_count", coin_count, exp_count);

    // Fill the counter to saturation, then press once more.
    while (exp_count < 255) begin
      press(2'($urandom_range(1, 3)), 8);
    end
    chk("count_full", coin_count, 255);
    press(2'b11, 9);
    chk("count_sat", coin_count, 255);

    // Reset during PRESS_WAIT (cnt=2) with the key held through reset.
    @(negedge clock);
    coin_sel = 2'b10;
    key_n    = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_coin_valid", coin_valid, 0);
    chk("abort_reject",     reject,     0);
    chk("abort_coin",       coin,       0);
    chk("abort_busy",       busy,       0);
    chk("abort_count",      coin_count, 0);
    reset     = 1'b0;
    exp_count = 0;
    push_exp(2'b10);
    repeat (10) @(negedge clock);
    key_n = 1'b1;
    wait_idle();
    chk("post_reset_count", coin_count, 1);

    repeat (5) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_entry_conditioner.md
COIN_ENTRY_CONDITIONER -- requirements
Module: coin_entry_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, number of consecutive stable clock cycles (D) required to accept a press or a release; legal range 2..65535.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 key_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock, bouncy.
REQ-005 coin_sel  input  2  raw coin-type switches, asynchronous; 00 = none, 01/10/11 = coin types.
REQ-006 coin  output  2  coin code to the vending FSM; 00 in every cycle except an accepted-coin cycle.
REQ-007 coin_valid  output  1  one-cycle pulse marking an accepted coin.
REQ-008 reject  output  1  one-cycle pulse when a debounced press is seen with coin_sel synchronized as 00.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 coin_count  output  8  count of accepted coins, saturating.

Function
REQ-011 key_n and coin_sel SHALL each pass through a 2-flop synchronizer; key_s and sel_s denote the second-stage outputs.
REQ-012 The FSM SHALL have states IDLE, PRESS_WAIT, EMIT, HELD, RELEASE_WAIT, and one shared 16-bit counter cnt.
REQ-013 IDLE: key_s=0 -> PRESS_WAIT with cnt=0; otherwise stay.
REQ-014 PRESS_WAIT: key_s=1 -> IDLE (bounce rejected, no output); key_s=0 and cnt=D-1 -> EMIT, latching sel_s into coin_lat; else cnt+1.
REQ-015 EMIT lasts exactly one cycle, then -> HELD unconditionally.
REQ-016 In EMIT with coin_lat != 00: coin=coin_lat, coin_valid=1, reject=0; coin_count increments by 1 unless already 255.
REQ-017 In EMIT with coin_lat = 00: coin=00, coin_valid=0, reject=1; coin_count unchanged.
REQ-018 Outside EMIT: coin=00, coin_valid=0, reject=0 (all registered outputs, no combinational path from inputs).
REQ-019 HELD: key_s=1 -> RELEASE_WAIT with cnt=0; otherwise stay (a held key yields exactly one coin).
REQ-020 RELEASE_WAIT: key_s=0 -> HELD; key_s=1 and cnt=D-1 -> IDLE; else cnt+1.
REQ-021 Latency: with key_n held low from before edge 0, coin_valid SHALL be high in the cycle after edge D+2 and low in every other cycle of that press.
REQ-022 coin_sel changes after the EMIT latch SHALL NOT affect coin for that press.
REQ-023 coin_count SHALL saturate at 255 and never wrap.
REQ-024 busy SHALL be 0 in IDLE and 1 in all other states, registered with state.

Reset
REQ-025 On reset=1 at a rising edge: state=IDLE, cnt=0, coin_lat=00, coin=00, coin_valid=0, reject=0, coin_count=0, both key_n synchronizer flops=1, coin_sel synchronizer flops=00.
REQ-026 Reset SHALL take priority over every transition, including mid-PRESS_WAIT, EMIT, and RELEASE_WAIT; an aborted press produces no pulse.
REQ-027 A key held low through deassertion of reset SHALL be treated as a new press and accepted after the normal debounce.

Verification (D=4)
REQ-028 coin_sel=10, key_n low from edge 0 held 20 cycles -> single coin_valid pulse with coin=10 in cycle after edge 6; coin_count 0->1; busy high from edge 2.
REQ-029 key_n glitches low for 3 cycles then high -> no coin_valid, no reject, state back to IDLE, coin_count unchanged.
REQ-030 Valid press, then release bouncing (high 2, low 1, high 10) -> exactly one coin_valid; IDLE reached 4 cycles after final stable-high key_s.
REQ-031 coin_sel=00 press -> reject pulse for one cycle, coin=00, coin_valid=0, coin_count unchanged.
REQ-032 coin_count preloaded to 255 via 255 presses, one more press with coin_sel=11 -> coin_valid=1, coin=11, coin_count stays 255.
REQ-033 Reset asserted during PRESS_WAIT (cnt=2) -> no pulse, all outputs 0 next cycle; key still low after reset -> one coin accepted after debounce.
